conv_encoder_gen: RTL and testbench
===================================

CONV_ENCODER_GEN -- requirements
Module: conv_encoder_gen

Interface
REQ-001 Parameter K, default 7, constraint length, legal range 3..9.
REQ-002 Parameter G0, default 7'o171, K-bit generator polynomial for out_data[0]; MSB taps the current input bit.
REQ-003 Parameter G1, default 7'o133, K-bit generator polynomial for out_data[1]; MSB taps the current input bit.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_bit and in_last are valid.
REQ-007 in_ready  output  1  the block accepts the input bit this cycle.
REQ-008 in_bit  input  1  information bit.
REQ-009 in_last  input  1  marks the last information bit of a frame.
REQ-010 out_valid  output  1  codeword is valid.
REQ-011 out_ready  input  1  the sink accepts the codeword.
REQ-012 out_data  output  2  codeword; bit0 from G0, bit1 from G1.
REQ-013 out_mask  output  2  per-bit transmit flag; a 0 bit is punctured.
REQ-014 out_last  output  1  marks the final tail codeword of a frame.

Function
REQ-015 Shift register sr[K-2:0] holds past inputs, sr[K-2] most recent; on each encoded bit b: sr <= {b, sr[K-2:1]}.
REQ-016 Codeword bit i SHALL be the XOR-reduction of (Gi & {b, sr}).
REQ-017 in_ready = !reset && state!=TAIL && (!out_valid || out_ready).
REQ-018 An accepted input SHALL load the output register on the same edge, so out_valid rises one cycle after acceptance (latency 1).
REQ-019 While out_valid && !out_ready, out_data, out_mask and out_last SHALL hold stable.
REQ-020 States: IDLE (sr zero), DATA, TAIL.
REQ-021 Transitions: from IDLE or DATA, an accepted bit without in_last goes to DATA; an accepted bit with in_last goes to TAIL and loads tail_cnt = K-1.
REQ-022 In TAIL, each free output slot encodes b=0 and decrements tail_cnt; the codeword issued at tail_cnt==1 carries out_last=1, after which the state is IDLE and sr is zero.
REQ-023 A frame of L bits SHALL produce exactly L+K-1 codewords; a single-bit frame (in_last on the first bit) is legal.
REQ-024 in_last on a bit accepted in the same cycle that the previous frame's last tail word is handed off SHALL be accepted without a lost cycle.
REQ-025 Without puncturing, out_mask SHALL be 2'b11.

Reset
REQ-026 Reset SHALL asynchronously clear out_valid, out_data, out_mask, out_last, sr, tail_cnt and the puncture phase, and set state=IDLE.
REQ-027 Reset mid-frame SHALL abort the frame with no out_last and no tail emitted.

Configuration
REQ-028 Macro CONV_ENC_PUNCTURE_EN: when defined, input port punct_en (1 bit) exists and is sampled on the first accepted bit of each frame and held for the whole frame.
REQ-029 With the macro defined and punct_en=1, rate 2/3 SHALL apply: a phase bit toggles per issued codeword, with phase 0 giving mask 11 and phase 1 giving mask 01 and out_data[1] forced to 0. Phase clears at frame start, and tail words are punctured too.
REQ-030 Without the macro, there is no punct_en port, no phase logic, and out_mask is tied to 2'b11.

Structure
REQ-031 Package conv_enc_pkg holds the state enum, default polynomials, the parity function and the puncture mask constants.
REQ-032 Sub-module conv_enc_punct (phase flop and mask/zeroing) SHALL be instantiated only under CONV_ENC_PUNCTURE_EN.

Verification
REQ-033 K=3, G0=3'o7, G1=3'o5, input 1,1,0,1 with in_last on the 4th bit and out_ready=1 -> out_data 11,10,10,00,01,11, with out_last only on the 6th.
REQ-034 Defaults (K=7), single bit 1 with in_last -> 11,01,11,11,00,10,11, with out_last on the 7th, then IDLE.
REQ-035 Hold out_ready=0 for 3 cycles mid-frame -> out_data stable, in_ready=0, no codeword lost or duplicated.
REQ-036 Reset pulse after 2 of 4 bits -> outputs 0 next cycle, no out_last; a new frame then encodes from zero state.
REQ-037 Macro defined, punct_en=1, the REQ-033 stimulus -> masks 11,01,11,01,11,01 and data 11,00,10,00,01,01.
REQ-038 Back-to-back frames with the next first bit offered during the final tail handoff -> no bubble, and the second frame's codewords match the single-frame result.

Source files
------------

// File: rtl/conv_enc_pkg.sv
// Shared constants for the convolutional encoder: FSM state codes, default
// generator polynomials, the parity helper and the puncture mask patterns.
package conv_enc_pkg;

   localparam int K_MAX = 9;

   localparam logic [6:0] G0_DEF = 7'o171;
   localparam logic [6:0] G1_DEF = 7'o133;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_DATA = 2'd1;
   localparam state_t ST_TAIL = 2'd2;

   localparam logic [1:0] MASK_FULL  = 2'b11;
   localparam logic [1:0] MASK_PUNCT = 2'b01;

   function automatic logic parity(input logic [K_MAX-1:0] taps);
      return ^taps;
   endfunction

endpackage

// File: rtl/conv_encoder_gen_if.sv
// Input bit stream and output codeword stream of the convolutional encoder,
// both valid/ready handshakes. The encoder uses the slave modport.
interface conv_encoder_gen_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_bit;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_data;
   logic [1:0] out_mask;
   logic       out_last;

   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_mask, out_last
   );

   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_data, out_mask, out_last
   );
endinterface

// File: rtl/conv_enc_punct.sv
// Rate-2/3 puncturing: phase flop and per-frame enable, only built with
// CONV_ENC_PUNCTURE_EN defined.
`ifdef CONV_ENC_PUNCTURE_EN
module conv_enc_punct
   import conv_enc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       punct_en,
   input  logic       frame_start,
   input  logic       issue,
   input  logic [1:0] code_raw,
   output logic [1:0] code,
   output logic [1:0] mask
);

   logic phase;
   logic en_q;
   logic en_eff;
   logic phase_cur;

   // the first word of a frame already uses the freshly sampled enable and phase 0
   assign en_eff    = frame_start ? punct_en : en_q;
   assign phase_cur = frame_start ? 1'b0 : phase;
   assign mask      = (en_eff && phase_cur) ? MASK_PUNCT : MASK_FULL;
   assign code      = code_raw & mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= 1'b0;
         en_q  <= 1'b0;
      end else begin
         if (frame_start)
            en_q <= punct_en;
         if (issue)
            phase <= ~phase_cur;
      end
   end

endmodule
`endif

// File: rtl/conv_encoder_gen.sv
// Rate-1/2 convolutional encoder with zero-tail termination and a registered
// codeword output. Optional rate-2/3 puncturing under CONV_ENC_PUNCTURE_EN.
//
// state   | meaning
// IDLE    | between frames, shift register is zero
// DATA    | frame in progress, accepting information bits
// TAIL    | flushing K-1 zero bits, input stalled
module conv_encoder_gen
   import conv_enc_pkg::*;
#(
   parameter int           K  = 7,
   parameter logic [K-1:0] G0 = K'(G0_DEF),
   parameter logic [K-1:0] G1 = K'(G1_DEF)
)(
   input  logic clk,
   input  logic reset,
`ifdef CONV_ENC_PUNCTURE_EN
   input  logic punct_en,
`endif
   conv_encoder_gen_if.slave bus
);

   localparam int CW = $clog2(K);

   state_t        state;
   logic [K-2:0]  sr;
   logic [CW-1:0] tail_cnt;

   logic          slot_free;
   logic          accept;
   logic          tail_step;
   logic          issue;
   logic          frame_start;
   logic          b;
   logic          last_word;
   logic [K-1:0]  taps;
   logic [1:0]    code_raw;
   logic [1:0]    code;
   logic [1:0]    mask;

   assign slot_free    = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = !reset && (state != ST_TAIL) && slot_free;
   assign accept       = bus.in_valid && bus.in_ready;
   assign tail_step    = (state == ST_TAIL) && slot_free;
   assign issue        = accept || tail_step;
   assign frame_start  = accept && (state == ST_IDLE);
   assign b            = accept ? bus.in_bit : 1'b0;
   assign last_word    = tail_step && (tail_cnt == CW'(1));

   assign taps     = {b, sr};
   assign code_raw = {parity(K_MAX'(taps & G1)), parity(K_MAX'(taps & G0))};

`ifdef CONV_ENC_PUNCTURE_EN
   conv_enc_punct u_punct (
      .clk         (clk),
      .reset       (reset),
      .punct_en    (punct_en),
      .frame_start (frame_start),
      .issue       (issue),
      .code_raw    (code_raw),
      .code        (code),
      .mask        (mask)
   );
`else
   assign code = code_raw;
   assign mask = MASK_FULL;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         sr            <= '0;
         tail_cnt      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= 2'b00;
         bus.out_mask  <= 2'b00;
         bus.out_last  <= 1'b0;
      end else begin
         if (issue) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= code;
            bus.out_mask  <= mask;
            bus.out_last  <= last_word;
            sr            <= last_word ? '0 : {b, sr[K-2:1]};
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end

         if (accept) begin
            if (bus.in_last) begin
               state    <= ST_TAIL;
               tail_cnt <= CW'(K-1);
            end else begin
               state <= ST_DATA;
            end
         end else if (tail_step) begin
            tail_cnt <= tail_cnt - CW'(1);
            if (last_word)
               state <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_conv_encoder_gen.sv
// Bench for conv_encoder_gen: K=3 and K=7 instances, fixed vectors plus
// randomized frames checked against a convolution reference model.
module tb_conv_encoder_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic sel;
   logic in_valid_c, in_bit_c, in_last_c, out_ready_c, punct_en_c;
   logic o_valid, o_last, in_ready_c;
   logic [1:0] o_data, o_mask;

   conv_encoder_gen_if bus3();
   conv_encoder_gen_if bus7();

   assign bus3.in_valid  = in_valid_c && !sel;
   assign bus7.in_valid  = in_valid_c && sel;
   assign bus3.in_bit    = in_bit_c;
   assign bus7.in_bit    = in_bit_c;
   assign bus3.in_last   = in_last_c;
   assign bus7.in_last   = in_last_c;
   assign bus3.out_ready = out_ready_c;
   assign bus7.out_ready = out_ready_c;

   assign o_valid    = sel ? bus7.out_valid : bus3.out_valid;
   assign o_last     = sel ? bus7.out_last  : bus3.out_last;
   assign o_data     = sel ? bus7.out_data  : bus3.out_data;
   assign o_mask     = sel ? bus7.out_mask  : bus3.out_mask;
   assign in_ready_c = sel ? bus7.in_ready  : bus3.in_ready;

   conv_encoder_gen #(.K(3), .G0(3'o7), .G1(3'o5)) dut3 (
      .clk      (clk),
      .reset    (reset),
`ifdef CONV_ENC_PUNCTURE_EN
      .punct_en (punct_en_c),
`endif
      .bus      (bus3.slave)
   );

   conv_encoder_gen dut7 (
      .clk      (clk),
      .reset    (reset),
`ifdef CONV_ENC_PUNCTURE_EN
      .punct_en (punct_en_c),
`endif
      .bus      (bus7.slave)
   );

   int errors = 0;
   int checks = 0;

   bit       frame_bits[$];
   bit       frame_lasts[$];
   logic [4:0] exp_q[$];
   logic [4:0] recv[$];
   int       rdy_pat[$];

   typedef struct {
      logic        sel;
      logic        punct;
      int          n;
      logic [7:0]  bits;
      int          nw;
      logic [15:0] data;
      logic [15:0] mask;
   } vec_t;

   vec_t tbl[3];
   int   nvec;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference: each codeword bit is the generator-weighted XOR of the current
   // and previous K-1 inputs of the frame, with zeros before the frame and after it
   task automatic model_frame(input int s, input int len);
      int k;
      logic [8:0] g0, g1;
      k  = sel ? 7 : 3;
      g0 = sel ? 9'o171 : 9'o7;
      g1 = sel ? 9'o133 : 9'o5;
      for (int t = 0; t < len + k - 1; t++) begin
         logic c0, c1;
         logic [1:0] m, d;
         c0 = 1'b0;
         c1 = 1'b0;
         for (int j = 0; j < k; j++) begin
            if (t - j >= 0 && t - j < len) begin
               c0 = c0 ^ (g0[k-1-j] & frame_bits[s+t-j]);
               c1 = c1 ^ (g1[k-1-j] & frame_bits[s+t-j]);
            end
         end
         m = (punct_en_c && (t % 2 == 1)) ? 2'b01 : 2'b11;
         d = {c1, c0} & m;
         exp_q.push_back({(t == len + k - 2), m, d});
      end
   endtask

   task automatic build_expected();
      int start;
      start = 0;
      exp_q.delete();
      for (int i = 0; i < frame_bits.size(); i++) begin
         if (frame_lasts[i]) begin
            model_frame(start, i - start + 1);
            start = i + 1;
         end
      end
   endtask

   task automatic run_stream(input string name, input int ready_pct, input int budget);
      int idx, cyc, n;
      logic prev_stall, acc;
      logic [4:0] prev_word;
      idx = 0;
      cyc = 0;
      n = frame_bits.size();
      prev_stall = 1'b0;
      prev_word = '0;
      recv.delete();
      while ((idx < n || recv.size() < exp_q.size()) && cyc < budget) begin
         in_valid_c  = (idx < n);
         in_bit_c    = (idx < n) ? frame_bits[idx] : 1'b0;
         in_last_c   = (idx < n) ? frame_lasts[idx] : 1'b0;
         out_ready_c = (cyc < rdy_pat.size()) ? (rdy_pat[cyc] != 0)
                                              : ($urandom_range(99) < ready_pct);
         #1;
         acc = in_valid_c && in_ready_c;
         if (prev_stall) begin
            check({name, "_hold_valid"}, 32'(o_valid), 32'd1);
            check({name, "_hold_word"}, 32'({o_last, o_mask, o_data}), 32'(prev_word));
         end
         if (o_valid && !out_ready_c) begin
            check({name, "_stall_in_ready"}, 32'(in_ready_c), 32'd0);
            prev_stall = 1'b1;
            prev_word  = {o_last, o_mask, o_data};
         end else begin
            prev_stall = 1'b0;
         end
         if (o_valid && out_ready_c) begin
            recv.push_back({o_last, o_mask, o_data});
            if (o_last && idx < n)
               check({name, "_no_bubble"}, 32'(acc), 32'd1);
         end
         if (acc)
            idx++;
         @(negedge clk);
         cyc++;
      end
      in_valid_c  = 1'b0;
      in_last_c   = 1'b0;
      out_ready_c = 1'b1;
      check({name, "_in_budget"}, 32'(cyc < budget), 32'd1);
      check({name, "_count"}, 32'(recv.size()), 32'(exp_q.size()));
      for (int i = 0; i < recv.size() && i < exp_q.size(); i++)
         check($sformatf("%s_word%0d", name, i), 32'(recv[i]), 32'(exp_q[i]));
      #1;
      check({name, "_idle_valid"}, 32'(o_valid), 32'd0);
      check({name, "_idle_ready"}, 32'(in_ready_c), 32'd1);
      @(negedge clk);
      rdy_pat.delete();
   endtask

   task automatic load_frame_1101();
      frame_bits.delete();
      frame_lasts.delete();
      frame_bits  = '{1'b1, 1'b1, 1'b0, 1'b1};
      frame_lasts = '{1'b0, 1'b0, 1'b0, 1'b1};
   endtask

   initial begin
      sel = 1'b0;
      in_valid_c = 1'b0;
      in_bit_c = 1'b0;
      in_last_c = 1'b0;
      out_ready_c = 1'b1;
      punct_en_c = 1'b0;

      tbl[0] = '{sel: 1'b0, punct: 1'b0, n: 4, bits: 8'h0B, nw: 6, data: 16'h0D2B, mask: 16'h0FFF};
      tbl[1] = '{sel: 1'b1, punct: 1'b0, n: 1, bits: 8'h01, nw: 7, data: 16'h38F7, mask: 16'h3FFF};
      tbl[2] = '{sel: 1'b0, punct: 1'b1, n: 4, bits: 8'h0B, nw: 6, data: 16'h0523, mask: 16'h0777};
      nvec = 2;
`ifdef CONV_ENC_PUNCTURE_EN
      nvec = 3;
`endif

      // reset state
      #1;
      check("rst_in_ready", 32'(in_ready_c), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready_c), 32'd1);
      check("post_rst_word", 32'({o_valid, o_last, o_mask, o_data}), 32'd0);
      @(negedge clk);

      // fixed vectors
      for (int i = 0; i < nvec; i++) begin
         sel = tbl[i].sel;
         punct_en_c = tbl[i].punct;
         frame_bits.delete();
         frame_lasts.delete();
         for (int j = 0; j < tbl[i].n; j++) begin
            frame_bits.push_back(tbl[i].bits[j]);
            frame_lasts.push_back(j == tbl[i].n - 1);
         end
         exp_q.delete();
         for (int j = 0; j < tbl[i].nw; j++)
            exp_q.push_back({(j == tbl[i].nw - 1), tbl[i].mask[2*j+:2], tbl[i].data[2*j+:2]});
         run_stream($sformatf("vec%0d", i), 100, 200);
      end
      punct_en_c = 1'b0;

      // sink stall of three cycles mid-frame
      sel = 1'b0;
      load_frame_1101();
      build_expected();
      rdy_pat = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
      run_stream("stall", 100, 200);

      // reset after two of four bits
      sel = 1'b0;
      in_valid_c = 1'b1;
      in_bit_c = 1'b1;
      in_last_c = 1'b0;
      out_ready_c = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("abort_accept", 32'(in_ready_c), 32'd1);
         @(negedge clk);
      end
      in_valid_c = 1'b0;
      #1;
      check("abort_pre_valid", 32'(o_valid), 32'd1);
      check("abort_pre_last", 32'(o_last), 32'd0);
      reset = 1'b1;
      #1;
      check("abort_word", 32'({o_valid, o_last, o_mask, o_data}), 32'd0);
      @(negedge clk);
      #1;
      check("abort_next_word", 32'({o_valid, o_last, o_mask, o_data}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      load_frame_1101();
      build_expected();
      run_stream("after_abort", 100, 200);

      // back-to-back frames, next frame offered during the last tail handoff
      sel = 1'b0;
      load_frame_1101();
      frame_bits  = {frame_bits, frame_bits};
      frame_lasts = {frame_lasts, frame_lasts};
      build_expected();
      run_stream("b2b", 100, 200);
      sel = 1'b1;
      frame_bits  = '{1'b1, 1'b0, 1'b1, 1'b1};
      frame_lasts = '{1'b0, 1'b1, 1'b0, 1'b1};
      build_expected();
      run_stream("b2b7", 100, 200);

      // randomized frames on both instances
      for (int r = 0; r < 8; r++) begin
         sel = r[0];
         frame_bits.delete();
         frame_lasts.delete();
         for (int f = 0; f < 3; f++) begin
            int len;
            len = $urandom_range(6, 1);
            for (int j = 0; j < len; j++) begin
               frame_bits.push_back($urandom_range(1, 0) == 1);
               frame_lasts.push_back(j == len - 1);
            end
         end
         build_expected();
         run_stream($sformatf("rand%0d", r), 65, 600);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
